debounce_multicanal: RTL and testbench
======================================

// Module: debounce_multicanal
// PURPOSE
//  N-channel debouncer for buttons/sensors. Each channel: 2-FF synchronizer, stability filter,
//  clean level output, 1-cycle rise/fall pulses and a 1-cycle long-press pulse.
//  Sits between raw board pins and control FSMs. Supersedes per-pin single-channel debounce
//  instances.
// PARAMETERS
//  N_CANAIS       4           number of independent channels (>=1)
//  FREQ_CLK_HZ    25_000_000  clock frequency in Hz
//  TEMPO_MS       20          stability time before a level change is accepted, in ms
//  TEMPO_LONGO_MS 1000        time the filtered level must stay 1 before pulso_longo fires, in ms
//  ATIVO_BAIXO    0           1 = raw inputs active-low; inverted right after the synchronizer
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         asynchronous, active-low reset
//  sinal_bruto    in   N_CANAIS  raw pin levels, asynchronous to clk
//  estado         out  N_CANAIS  debounced logical level (1 = active)
//  pulso_subida   out  N_CANAIS  1-cycle pulse when estado goes 0->1
//  pulso_descida  out  N_CANAIS  1-cycle pulse when estado goes 1->0
//  pulso_longo    out  N_CANAIS  1-cycle pulse, at most once per press
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-low. No synchronous reset.
//  - While rst_n=0, all of the following are 0:
//      sync FFs (logical, after polarity), counters, estado, pulso_*.
//  - Derived cycle counts:
//      CICLOS_DEB   = FREQ_CLK_HZ/1000*TEMPO_MS
//      CICLOS_LONGO = FREQ_CLK_HZ/1000*TEMPO_LONGO_MS
//    Elaboration error if either is < 1.
//  - Counter widths: $clog2(CICLOS_x+1). All arithmetic is unsigned. Counters never wrap.
//  - Synchronizer: 2 FFs per channel. s = sync2 ^ ATIVO_BAIXO.
//  - Filter (per channel), counter cnt:
//      s == estado: cnt <= 0.
//      s != estado and cnt == CICLOS_DEB-1: estado <= s, cnt <= 0.
//      s != estado otherwise: cnt <= cnt+1.
//    A change must be seen for CICLOS_DEB consecutive cycles.
//    Any glitch back to estado restarts the count.
//  - Latency from a clean raw edge to the estado change: 2 + CICLOS_DEB cycles.
//  - Pulses are registered and aligned with the estado change.
//    pulso_subida/descida are 1 in exactly the first cycle estado shows its new value.
//  - Long press: counter cl with a done flag.
//      Cleared while estado=0.
//      Counts while estado=1, saturating.
//      pulso_longo=1 for one cycle when cl reaches CICLOS_LONGO (cycle CICLOS_LONGO after the
//      rise). Then the done flag blocks further pulses until estado returns to 0.
//  - Release on the same edge that cl would hit CICLOS_LONGO: pulso_descida only, no pulso_longo.
//  - Channels are fully independent. Simultaneous events on several channels produce pulses in
//    the same cycle.
//  - Input already active at reset release: treated as a fresh press. pulso_subida after the
//    normal latency.
//  - Reset asserted mid-count or mid-press: state clears immediately.
//    No pulse is emitted by the reset itself, either at assertion or release.
// STRUCTURE
//  - Package debounce_pkg:
//      function ms_para_ciclos(freq_hz, ms)
//      function largura_contador(ciclos) returning $clog2(ciclos+1)
//  - Sub-module debounce_canal:
//      one channel (synchronizer, filter, edge and long-press logic), 1-bit ports.
//      Top instantiates N_CANAIS copies in a generate loop.
//  - No cross-channel logic.
// TESTING  (FREQ_CLK_HZ=1000 gives CICLOS_DEB=4 and CICLOS_LONGO=20; N_CANAIS=4)
//  1. Reset, inputs 0:
//     rst_n=0 for 3 cycles, then 1 -> all outputs 0. No pulses for 50 cycles.
//  2. Clean press on ch0 (0->1, held 10 cycles):
//     estado[0]=1 and pulso_subida[0]=1 in cycle 6 after the edge, for 1 cycle.
//     Channels 1-3 stay silent.
//  3. Bounce on ch1 (toggle every 2 cycles for 12 cycles, then stable 1):
//     exactly one pulso_subida[1], 6 cycles after the last toggle. No pulso_descida.
//  4. Long press on ch2 (held 30 cycles after the rise, then released):
//     pulso_longo[2] once, 20 cycles after the rise. Then pulso_descida[2] 6 cycles after the
//     release. No second pulso_longo.
//  5. Simultaneous ch0 and ch3 press, plus an ATIVO_BAIXO=1 instance with raw idle 1:
//     both channels pulse in the same cycle. Inverted instance: raw 1->0 gives pulso_subida.
//  6. rst_n pulled low 2 cycles into the count and also mid long-press:
//     estado and counters go to 0 asynchronously. No pulso_* at reset release with input 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared helpers for the multichannel debouncer: time-to-cycles conversion and counter sizing.
package debounce_pkg;

   function automatic int ms_para_ciclos(input int freq_hz, input int ms);
      return (freq_hz / 1000) * ms;
   endfunction

   function automatic int largura_contador(input int ciclos);
      return $clog2(ciclos + 1);
   endfunction

endpackage

// File: rtl/debounce_canal.sv
// One debounced channel: 2-FF synchronizer, stability filter, edge pulses and long-press pulse.
module debounce_canal
   import debounce_pkg::*;
#(
   parameter int CICLOS_DEB   = 4,
   parameter int CICLOS_LONGO = 20,
   parameter bit ATIVO_BAIXO  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sinal_bruto,
   output logic estado,
   output logic pulso_subida,
   output logic pulso_descida,
   output logic pulso_longo
);

   localparam int W_DEB   = largura_contador(CICLOS_DEB);
   localparam int W_LONGO = largura_contador(CICLOS_LONGO);

   localparam logic [W_DEB-1:0]   DEB_ULTIMO   = W_DEB'(CICLOS_DEB - 1);
   localparam logic [W_LONGO-1:0] LONGO_ULTIMO = W_LONGO'(CICLOS_LONGO - 1);
   localparam logic [W_LONGO-1:0] LONGO_FIM    = W_LONGO'(CICLOS_LONGO);

   logic               sync1_reg, sync2_reg;
   logic               estado_reg;
   logic [W_DEB-1:0]   cnt_reg;
   logic [W_LONGO-1:0] cl_reg;
   logic               done_reg;
   logic               subida_reg, descida_reg, longo_reg;
   logic               s, aceita, longo_next;

   // Sync FFs reset to the idle raw level so the logical value is 0 for either polarity.
   assign s          = sync2_reg ^ ATIVO_BAIXO;
   assign aceita     = (s != estado_reg) && (cnt_reg == DEB_ULTIMO);
   // A release landing on the same edge as the long-press threshold suppresses the pulse.
   assign longo_next = estado_reg && !done_reg && (cl_reg == LONGO_ULTIMO) && !aceita;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg   <= ATIVO_BAIXO;
         sync2_reg   <= ATIVO_BAIXO;
         estado_reg  <= 1'b0;
         cnt_reg     <= '0;
         cl_reg      <= '0;
         done_reg    <= 1'b0;
         subida_reg  <= 1'b0;
         descida_reg <= 1'b0;
         longo_reg   <= 1'b0;
      end else begin
         sync1_reg <= sinal_bruto;
         sync2_reg <= sync1_reg;

         if (s == estado_reg) begin
            cnt_reg <= '0;
         end else if (aceita) begin
            estado_reg <= s;
            cnt_reg    <= '0;
         end else begin
            cnt_reg <= cnt_reg + W_DEB'(1);
         end

         subida_reg  <= aceita && s;
         descida_reg <= aceita && !s;
         longo_reg   <= longo_next;

         if (!estado_reg) begin
            cl_reg   <= '0;
            done_reg <= 1'b0;
         end else begin
            if (cl_reg != LONGO_FIM) cl_reg <= cl_reg + W_LONGO'(1);
            if (longo_next)          done_reg <= 1'b1;
         end
      end
   end

   assign estado        = estado_reg;
   assign pulso_subida  = subida_reg;
   assign pulso_descida = descida_reg;
   assign pulso_longo   = longo_reg;

endmodule

// File: rtl/debounce_multicanal.sv
// N independent debounce channels sharing one clock and asynchronous active-low reset.
module debounce_multicanal
   import debounce_pkg::*;
#(
   parameter int N_CANAIS       = 4,
   parameter int FREQ_CLK_HZ    = 25_000_000,
   parameter int TEMPO_MS       = 20,
   parameter int TEMPO_LONGO_MS = 1000,
   parameter bit ATIVO_BAIXO    = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_CANAIS-1:0] sinal_bruto,
   output logic [N_CANAIS-1:0] estado,
   output logic [N_CANAIS-1:0] pulso_subida,
   output logic [N_CANAIS-1:0] pulso_descida,
   output logic [N_CANAIS-1:0] pulso_longo
);

   localparam int CICLOS_DEB   = ms_para_ciclos(FREQ_CLK_HZ, TEMPO_MS);
   localparam int CICLOS_LONGO = ms_para_ciclos(FREQ_CLK_HZ, TEMPO_LONGO_MS);

   if (CICLOS_DEB < 1) begin : g_erro_deb
      $error("debounce_multicanal: CICLOS_DEB must be >= 1");
   end
   if (CICLOS_LONGO < 1) begin : g_erro_longo
      $error("debounce_multicanal: CICLOS_LONGO must be >= 1");
   end

   for (genvar gi = 0; gi < N_CANAIS; gi++) begin : g_canal
      debounce_canal #(
         .CICLOS_DEB  (CICLOS_DEB),
         .CICLOS_LONGO(CICLOS_LONGO),
         .ATIVO_BAIXO (ATIVO_BAIXO)
      ) u_canal (
         .clk          (clk),
         .rst_n        (rst_n),
         .sinal_bruto  (sinal_bruto[gi]),
         .estado       (estado[gi]),
         .pulso_subida (pulso_subida[gi]),
         .pulso_descida(pulso_descida[gi]),
         .pulso_longo  (pulso_longo[gi])
      );
   end

endmodule

// File: tb/tb_debounce_multicanal.sv
// Randomized and directed bench; a history-based reference model predicts every output each cycle.
module tb_debounce_multicanal;

   localparam int DEB   = 4;
   localparam int LONGO = 20;
   localparam int NC    = 5;  // channels 0-3: active-high instance, channel 4: active-low instance

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] raw;
   logic [3:0] estado, pulso_subida, pulso_descida, pulso_longo;
   logic [0:0] raw_inv;
   logic [0:0] estado_i, subida_i, descida_i, longo_i;

   always #5 clk = ~clk;

   debounce_multicanal #(
      .N_CANAIS(4), .FREQ_CLK_HZ(1000), .TEMPO_MS(DEB), .TEMPO_LONGO_MS(LONGO), .ATIVO_BAIXO(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sinal_bruto(raw), .estado(estado),
      .pulso_subida(pulso_subida), .pulso_descida(pulso_descida), .pulso_longo(pulso_longo)
   );

   debounce_multicanal #(
      .N_CANAIS(1), .FREQ_CLK_HZ(1000), .TEMPO_MS(DEB), .TEMPO_LONGO_MS(LONGO), .ATIVO_BAIXO(1'b1)
   ) dut_inv (
      .clk(clk), .rst_n(rst_n), .sinal_bruto(raw_inv), .estado(estado_i),
      .pulso_subida(subida_i), .pulso_descida(descida_i), .pulso_longo(longo_i)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Reference model: logical raw samples per edge, delayed two edges, then a window of DEB samples.
   logic [NC-1:0] raw_q[$];
   logic [NC-1:0] s_q[$];
   logic [NC-1:0] m_est, e_sub, e_des, e_lon;
   int            rise_k[NC];
   int            k;

   task automatic model_reset();
      raw_q.delete();
      s_q.delete();
      m_est = '0; e_sub = '0; e_des = '0; e_lon = '0;
      k = 0;
      for (int c = 0; c < NC; c++) rise_k[c] = 0;
   endtask

   task automatic model_step(input logic [NC-1:0] raw_log);
      logic [NC-1:0] s;
      logic          todos_diferentes, novo;
      k++;
      raw_q.push_back(raw_log);
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      s = (raw_q.size() == 3) ? raw_q[0] : '0;
      s_q.push_back(s);
      if (s_q.size() > DEB) void'(s_q.pop_front());
      for (int c = 0; c < NC; c++) begin
         todos_diferentes = (s_q.size() == DEB);
         for (int i = 0; i < s_q.size(); i++)
            if (s_q[i][c] == m_est[c]) todos_diferentes = 1'b0;
         novo     = todos_diferentes ? ~m_est[c] : m_est[c];
         e_sub[c] = novo && !m_est[c];
         e_des[c] = !novo && m_est[c];
         e_lon[c] = m_est[c] && novo && (k - rise_k[c] == LONGO);
         if (e_sub[c]) rise_k[c] = k;
         m_est[c] = novo;
      end
   endtask

   task automatic compare_all();
      check("estado",        {3'b0, estado_i, estado},        {3'b0, m_est});
      check("pulso_subida",  {3'b0, subida_i, pulso_subida},  {3'b0, e_sub});
      check("pulso_descida", {3'b0, descida_i, pulso_descida}, {3'b0, e_des});
      check("pulso_longo",   {3'b0, longo_i, pulso_longo},    {3'b0, e_lon});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step({~raw_inv[0], raw});
      #1;
      compare_all();
   endtask

   // Asserts reset mid-cycle and checks the outputs clear before the next edge.
   task automatic do_reset(input int ciclos);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      repeat (ciclos) tick();
      rst_n = 1'b1;
   endtask

   int hold[NC];

   initial begin
      rst_n   = 1'b0;
      raw     = '0;
      raw_inv = 1'b1;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (50) tick();

      // Clean press on ch0
      raw[0] = 1'b1; repeat (10) tick();
      raw[0] = 1'b0; repeat (12) tick();

      // Bounce on ch1, then stable high
      for (int i = 0; i < 6; i++) begin
         raw[1] = ~raw[1]; repeat (2) tick();
      end
      raw[1] = 1'b1; repeat (15) tick();
      raw[1] = 1'b0; repeat (12) tick();

      // Long press on ch2
      raw[2] = 1'b1; repeat (36) tick();
      raw[2] = 1'b0; repeat (30) tick();

      // Release lands on the same edge the long-press threshold would be reached
      raw[2] = 1'b1; repeat (20) tick();
      raw[2] = 1'b0; repeat (30) tick();

      // Simultaneous ch0/ch3 press plus inverted instance pressed (raw 1->0)
      raw[0] = 1'b1; raw[3] = 1'b1; raw_inv = 1'b0; repeat (30) tick();
      raw = '0; raw_inv = 1'b1; repeat (12) tick();

      // Reset during the debounce count and during a long press
      raw[1] = 1'b1; repeat (2) tick();
      raw[1] = 1'b0; do_reset(2); repeat (12) tick();
      raw[2] = 1'b1; repeat (15) tick();
      raw[2] = 1'b0; do_reset(3); repeat (20) tick();

      // Input held active across reset release is a fresh press
      raw[3] = 1'b1; raw_inv = 1'b0; repeat (10) tick();
      do_reset(2); repeat (30) tick();
      raw = '0; raw_inv = 1'b1; repeat (12) tick();

      // Random phase: mixes bounces and long holds, with occasional async resets
      for (int c = 0; c < NC; c++) hold[c] = 0;
      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < NC; c++) begin
            if (hold[c] == 0) begin
               if (c < 4) raw[c] = ~raw[c];
               else       raw_inv[0] = ~raw_inv[0];
               hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                     : int'($urandom_range(5, 35));
            end else begin
               hold[c]--;
            end
         end
         if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
         else                             tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
